awgn_channel_adder: RTL and testbench
=====================================

// Module: awgn_channel_adder
// PURPOSE
// - Downstream consumer of the AWGN noise memory: adds one complex noise sample per symbol to a streamed complex signal.
// - Snapshots the packed SIZE x 32-bit real/imag noise buses once per frame.
// - Indexes the snapshot sample by sample and emits noisy symbols over a valid/ready stream to the receiver/demapper.
// PARAMETERS
// - SIZE   64  noise samples per frame (matches the noise memory depth); power of 2, >= 2
// - DW     32  bits per real/imag component, signed two's complement
// - IDXW   6   index width = $clog2(SIZE)
// PORTS
// - clk             in   1        rising-edge clock (single clock domain)
// - rst             in   1        synchronous, active-high reset
// - noise_real      in   SIZE*DW  packed noise real parts; sample i at [i*DW +: DW]
// - noise_imag      in   SIZE*DW  packed noise imag parts; same packing
// - in_valid        in   1        input symbol valid
// - in_ready        out  1        block accepts the symbol this cycle
// - in_real         in   DW       signal real part
// - in_imag         in   DW       signal imag part
// - out_valid       out  1        output symbol valid
// - out_ready       in   1        downstream accepts the output
// - out_real        out  DW       signal + noise, real
// - out_imag        out  DW       signal + noise, imag
// - out_idx         out  IDXW     noise index used for this output
// - frame_done      out  1        1-cycle pulse when the output of index SIZE-1 is accepted
// BEHAVIOUR
// - Reset: state=SNAP; idx=0; out_valid=0; out_real/out_imag/out_idx=0; frame_done=0; snapshot regs=0.
// - FSM SNAP: in_ready=0. Capture noise_real/noise_imag into the snapshot regs. Go to STREAM next cycle. SNAP lasts exactly 1 cycle.
// - FSM STREAM: in_ready = !out_valid || out_ready (1-deep output register).
// - Input transfer = in_valid && in_ready.
// - On a transfer: out_real <= in_real + snap_real[idx]; out_imag likewise; out_idx <= idx; out_valid <= 1; idx <= idx+1.
// - Latency: 1 cycle from input transfer to out_valid.
// - Full throughput: 1 symbol/cycle while out_ready=1.
// - out_valid clears on out_ready when no new transfer occurs that cycle.
// - The output holds stable while out_valid && !out_ready.
// - Wrap: a transfer at idx==SIZE-1 sets idx to 0 and moves the FSM to SNAP. The next frame uses a fresh snapshot.
//   The output of the last sample may still drain during SNAP.
// - frame_done: asserts in the cycle after the output with out_idx==SIZE-1 is accepted (out_valid && out_ready).
// - Simultaneous events: an output drain and a new input transfer in the same cycle are both legal.
//   The output register reloads and out_valid stays 1.
// - The noise buses are sampled only in SNAP. Changes at other times are ignored.
// - Reset mid-frame: all state returns to reset values. The in-flight output is dropped and the next frame restarts at idx 0.
// - Arithmetic: DW-bit signed add. Overflow behaviour is set by AWGN_SAT_EN.
// CONFIGURATION
// - AWGN_SAT_EN defined: each component saturates to +(2^(DW-1)-1) or -2^(DW-1) on signed overflow.
// - AWGN_SAT_EN undefined: plain two's-complement wrap-around (modulo 2^DW).
// STRUCTURE
// - Package awgn_pkg: DW/SIZE defaults, the state enum {SNAP, STREAM}, and function sat_add(a,b) returning DW bits.
// - Sub-module awgn_sat_adder: one complex adder instanced once, saturating or wrapping per AWGN_SAT_EN.
// - Top holds the FSM, the index counter, the snapshot regs and the output register.
// TESTING
// - Reset: hold rst 3 cycles -> out_valid=0, in_ready=0, frame_done=0. First cycle after release is SNAP; in_ready=1 one cycle later.
// - Streaming: noise_real[i]=i, noise_imag[i]=-i; input real=100, imag=200 for 64 symbols, out_ready=1.
//   -> out_real=100+i, out_imag=200-i, out_idx=i.
//   -> frame_done pulses once; in_ready drops for exactly 1 cycle (SNAP) after the 64th transfer.
// - Backpressure: out_ready=0 for 5 cycles mid-frame -> output held stable, in_ready=0, no index skipped.
//   On release the outputs continue in order.
// - Snapshot: change noise buses to all 1 during STREAM -> no effect until the next frame.
//   The next frame adds 1 to every sample.
// - Overflow: in_real=32'h7FFFFFF0, noise=32'h20.
//   -> 32'h7FFFFFFF with AWGN_SAT_EN; 32'h80000010 without.
//   Mirror negative case: 32'h80000000 + (-1) -> 32'h80000000 saturated.
// - Mid-frame reset: assert rst at idx=30 -> out_valid=0 next cycle. After release the first output has out_idx=0 using a fresh snapshot.

Source files
------------

// File: rtl/awgn_pkg.sv
// Shared widths, FSM state constants, complex payload type and saturating add for the AWGN channel adder.
package awgn_pkg;

  localparam int unsigned AWGN_DW   = 32;
  localparam int unsigned AWGN_SIZE = 64;
  localparam int unsigned AWGN_IDXW = $clog2(AWGN_SIZE);

  localparam logic [0:0] SNAP   = 1'b0;
  localparam logic [0:0] STREAM = 1'b1;

  typedef struct packed {
    logic [AWGN_DW-1:0] re;
    logic [AWGN_DW-1:0] im;
  } cplx_t;

  // Signed add clamped to the most positive / most negative DW-bit value on overflow.
  function automatic logic [AWGN_DW-1:0] sat_add(input logic [AWGN_DW-1:0] a,
                                                 input logic [AWGN_DW-1:0] b);
    logic [AWGN_DW-1:0] s;
    s = a + b;
    if ((a[AWGN_DW-1] == b[AWGN_DW-1]) && (s[AWGN_DW-1] != a[AWGN_DW-1])) begin
      s = a[AWGN_DW-1] ? {1'b1, {(AWGN_DW-1){1'b0}}} : {1'b0, {(AWGN_DW-1){1'b1}}};
    end
    return s;
  endfunction

endpackage

// File: rtl/awgn_channel_adder_if.sv
// Symbol stream bus of the AWGN channel adder: signal input, noisy output and frame pulse.
interface awgn_channel_adder_if #(
  parameter int unsigned IDXW = awgn_pkg::AWGN_IDXW
);
  logic                         in_valid;
  logic                         in_ready;
  logic [awgn_pkg::AWGN_DW-1:0] in_real;
  logic [awgn_pkg::AWGN_DW-1:0] in_imag;
  logic                         out_valid;
  logic                         out_ready;
  logic [awgn_pkg::AWGN_DW-1:0] out_real;
  logic [awgn_pkg::AWGN_DW-1:0] out_imag;
  logic [IDXW-1:0]              out_idx;
  logic                         frame_done;

  modport master (
    output in_valid, in_real, in_imag, out_ready,
    input  in_ready, out_valid, out_real, out_imag, out_idx, frame_done
  );

  modport slave (
    input  in_valid, in_real, in_imag, out_ready,
    output in_ready, out_valid, out_real, out_imag, out_idx, frame_done
  );
endinterface

// File: rtl/awgn_sat_adder.sv
// Complex signal+noise adder; saturating when AWGN_SAT_EN is defined, otherwise modulo 2^DW.
module awgn_sat_adder
  import awgn_pkg::*;
(
  input  cplx_t i_a,
  input  cplx_t i_b,
  output cplx_t o_sum_c
);

`ifdef AWGN_SAT_EN
  assign o_sum_c.re = sat_add(i_a.re, i_b.re);
  assign o_sum_c.im = sat_add(i_a.im, i_b.im);
`else
  assign o_sum_c.re = i_a.re + i_b.re;
  assign o_sum_c.im = i_a.im + i_b.im;
`endif

endmodule

// File: rtl/awgn_channel_adder.sv
// Adds one snapshotted complex noise sample per streamed symbol; snapshot refreshed once per frame.
// Overflow handling selected by AWGN_SAT_EN (see awgn_sat_adder).
module awgn_channel_adder
  import awgn_pkg::*;
#(
  parameter int unsigned SIZE = AWGN_SIZE
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [SIZE*AWGN_DW-1:0]   noise_real,
  input  logic [SIZE*AWGN_DW-1:0]   noise_imag,
  awgn_channel_adder_if.slave       bus
);

  localparam int unsigned DW   = AWGN_DW;
  localparam int unsigned IDXW = $clog2(SIZE);

  logic [0:0]         r_state;
  logic [0:0]         w_state_nxt;
  logic [IDXW-1:0]    r_idx;
  logic [SIZE*DW-1:0] r_snap_real;
  logic [SIZE*DW-1:0] r_snap_imag;
  logic               r_out_valid;
  logic [DW-1:0]      r_out_real;
  logic [DW-1:0]      r_out_imag;
  logic [IDXW-1:0]    r_out_idx;
  logic               r_frame_done;

  logic               w_in_ready;
  logic               w_xfer;
  logic               w_last;
  cplx_t              w_sig;
  cplx_t              w_noise;
  cplx_t              w_sum;

  // One-deep output register: accept whenever it is empty or being drained.
  assign w_in_ready = (r_state == STREAM) && (!r_out_valid || bus.out_ready);
  assign w_xfer     = bus.in_valid && w_in_ready;
  assign w_last     = (r_idx == IDXW'(SIZE - 1));

  assign w_sig.re   = bus.in_real;
  assign w_sig.im   = bus.in_imag;
  assign w_noise.re = r_snap_real[32'(r_idx) * DW +: DW];
  assign w_noise.im = r_snap_imag[32'(r_idx) * DW +: DW];

  awgn_sat_adder u_adder (
    .i_a     (w_sig),
    .i_b     (w_noise),
    .o_sum_c (w_sum)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SNAP:   w_state_nxt = STREAM;
      STREAM: if (w_xfer && w_last) w_state_nxt = SNAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SNAP;
      r_idx        <= '0;
      r_snap_real  <= '0;
      r_snap_imag  <= '0;
      r_out_valid  <= 1'b0;
      r_out_real   <= '0;
      r_out_imag   <= '0;
      r_out_idx    <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= r_out_valid && bus.out_ready && (r_out_idx == IDXW'(SIZE - 1));
      if (r_state == SNAP) begin
        r_snap_real <= noise_real;
        r_snap_imag <= noise_imag;
      end
      // A reload in the same cycle as a drain keeps out_valid high.
      if (w_xfer) begin
        r_out_valid <= 1'b1;
        r_out_real  <= w_sum.re;
        r_out_imag  <= w_sum.im;
        r_out_idx   <= r_idx;
        r_idx       <= r_idx + IDXW'(1);
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.out_valid  = r_out_valid;
  assign bus.out_real   = r_out_real;
  assign bus.out_imag   = r_out_imag;
  assign bus.out_idx    = r_out_idx;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_awgn_channel_adder.sv
// Randomized self-checking bench for awgn_channel_adder against a frame-level reference model.
module tb_awgn_channel_adder;
  import awgn_pkg::*;

  localparam int unsigned SIZE = 64;
  localparam int unsigned DW   = 32;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [SIZE*DW-1:0]   noise_real;
  logic [SIZE*DW-1:0]   noise_imag;
  logic [31:0]          nr [SIZE];
  logic [31:0]          ni [SIZE];

  awgn_channel_adder_if bus ();

  awgn_channel_adder #(.SIZE(SIZE)) dut (
    .clk        (clk),
    .rst        (rst),
    .noise_real (noise_real),
    .noise_imag (noise_imag),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] re;
    logic [31:0] im;
    int          idx;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_snap_r [SIZE];
  logic [31:0] m_snap_i [SIZE];
  int          m_idx;
  bit          m_need_snap;
  bit          m_fd_pending;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: signed sum in wide arithmetic, then clamp or truncate.
  function automatic logic [31:0] exp_add(input logic [31:0] a, input logic [31:0] b);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b));
`ifdef AWGN_SAT_EN
    if (s > 64'sd2147483647)  s = 64'sd2147483647;
    if (s < -64'sd2147483648) s = -64'sd2147483648;
`endif
    return s[31:0];
  endfunction

  task automatic pack_noise();
    for (int i = 0; i < SIZE; i++) begin
      noise_real[i*DW +: DW] = nr[i];
      noise_imag[i*DW +: DW] = ni[i];
    end
  endtask

  task automatic set_noise(input int mode);
    for (int i = 0; i < SIZE; i++) begin
      case (mode)
        0: begin nr[i] = 32'(i);   ni[i] = 32'(-i);        end
        1: begin nr[i] = 32'd1;    ni[i] = 32'd1;          end
        2: begin nr[i] = 32'h20;   ni[i] = 32'hFFFF_FFFF;  end
        default: begin nr[i] = $urandom; ni[i] = $urandom; end
      endcase
    end
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      pack_noise();
      #1;
      if (k > 0) begin
        check_eq("rst_out_valid",  32'(bus.out_valid),  32'd0);
        check_eq("rst_in_ready",   32'(bus.in_ready),   32'd0);
        check_eq("rst_frame_done", 32'(bus.frame_done), 32'd0);
      end
    end
    q.delete();
    m_idx        = 0;
    m_need_snap  = 1'b1;
    m_fd_pending = 1'b0;
  endtask

  // One clock cycle: drive, check against the model, then advance the model.
  task automatic step(input bit v, input logic [31:0] re, input logic [31:0] im, input bit ordy);
    bit   exp_rdy;
    bit   out_x;
    bit   in_x;
    exp_t e;
    @(negedge clk);
    rst           = 1'b0;
    bus.in_valid  = v;
    bus.in_real   = re;
    bus.in_imag   = im;
    bus.out_ready = ordy;
    pack_noise();
    #1;
    exp_rdy = !m_need_snap && ((q.size() == 0) || ordy);
    check_eq("in_ready",   32'(bus.in_ready),   32'(exp_rdy));
    check_eq("out_valid",  32'(bus.out_valid),  32'(q.size() != 0));
    check_eq("frame_done", 32'(bus.frame_done), 32'(m_fd_pending));
    m_fd_pending = 1'b0;
    if (q.size() != 0) begin
      check_eq("out_real", bus.out_real,     q[0].re);
      check_eq("out_imag", bus.out_imag,     q[0].im);
      check_eq("out_idx",  32'(bus.out_idx), 32'(q[0].idx));
    end
    out_x = (q.size() != 0) && ordy;
    in_x  = v && exp_rdy;
    if (m_need_snap) begin
      for (int i = 0; i < SIZE; i++) begin
        m_snap_r[i] = nr[i];
        m_snap_i[i] = ni[i];
      end
      m_need_snap = 1'b0;
    end
    if (out_x) begin
      if (q[0].idx == SIZE - 1) m_fd_pending = 1'b1;
      void'(q.pop_front());
    end
    if (in_x) begin
      e.re  = exp_add(re, m_snap_r[m_idx]);
      e.im  = exp_add(im, m_snap_i[m_idx]);
      e.idx = m_idx;
      q.push_back(e);
      if (m_idx == SIZE - 1) begin
        m_idx       = 0;
        m_need_snap = 1'b1;
      end else begin
        m_idx++;
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_real   = '0;
    bus.in_imag   = '0;
    bus.out_ready = 1'b0;
    set_noise(0);
    pack_noise();

    do_reset(3);

    // Ramp noise, constant symbol, full throughput across a frame boundary.
    for (int k = 0; k < 70; k++) step(1'b1, 32'd100, 32'd200, 1'b1);

    // Backpressure mid-frame, then noise change that must wait for the next frame.
    for (int k = 0; k < 10; k++) step(1'b1, 32'd100, 32'd200, 1'b1);
    for (int k = 0; k < 5; k++)  step(1'b1, 32'd100, 32'd200, 1'b0);
    set_noise(1);
    for (int k = 0; k < 120; k++) step(1'b1, 32'd100, 32'd200, 1'b1);

    // Overflow corners on a fresh snapshot.
    set_noise(2);
    do_reset(2);
    step(1'b0, 32'd0, 32'd0, 1'b1);
    step(1'b1, 32'h7FFF_FFF0, 32'h8000_0000, 1'b1);
    step(1'b0, 32'd0, 32'd0, 1'b1);
`ifdef AWGN_SAT_EN
    check_eq("ovf_pos_real", bus.out_real, 32'h7FFF_FFFF);
    check_eq("ovf_neg_imag", bus.out_imag, 32'h8000_0000);
`else
    check_eq("ovf_pos_real", bus.out_real, 32'h8000_0010);
    check_eq("ovf_neg_imag", bus.out_imag, 32'h7FFF_FFFF);
`endif

    // Random traffic with random backpressure and occasional noise changes.
    set_noise(3);
    for (int k = 0; k < 700; k++) begin
      if ($urandom_range(49) == 0) set_noise(3);
      step(1'($urandom_range(3) != 0), $urandom, $urandom, 1'($urandom_range(3) != 0));
    end

    // Reset in the middle of a frame at index 30.
    begin
      int guard;
      guard = 0;
      while (m_idx != 30 && guard < 300) begin
        step(1'b1, $urandom, $urandom, 1'b1);
        guard++;
      end
      check_eq("reach_idx30", 32'(m_idx), 32'd30);
    end
    set_noise(3);
    do_reset(2);
    for (int k = 0; k < 80; k++) step(1'b1, $urandom, $urandom, 1'($urandom_range(4) != 0));
    for (int k = 0; k < 4; k++)  step(1'b0, 32'd0, 32'd0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
